// File: rtl/al422_bam_pkg.sv
// Shared definitions for the AL422 BAM row reader.
// Optional build macro: AL422_BAM_BGR_EN selects B,G,R byte order per lane
// in the FIFO; the default build expects R,G,B.
package al422_bam_pkg;

  // Bit position of each colour inside one {B,G,R} lane of rgb_out.
  localparam int RGB_R = 0;
  localparam int RGB_G = 1;
  localparam int RGB_B = 2;

  // One byte per colour per lane for every pixel.
  function automatic int slots_per_pixel(input int channels);
    return 3 * channels;
  endfunction

  // FIFO bytes consumed by one full row.
  function automatic int total_reads(input int pixels, input int channels);
    return pixels * slots_per_pixel(channels);
  endfunction

  // Map a slot (lane base + colour index within the lane) to its bit in the
  // assembled pixel word. The FIFO byte order decides which colour a slot
  // carries. The rgb_out layout itself never changes.
  function automatic int slot_bit_pos(input int lane_base, input int color_idx);
    int colour;
`ifdef AL422_BAM_BGR_EN
    colour = (color_idx == 0) ? RGB_B : ((color_idx == 1) ? RGB_G : RGB_R);
`else
    colour = (color_idx == 0) ? RGB_R : ((color_idx == 1) ? RGB_G : RGB_B);
`endif
    return lane_base + colour;
  endfunction

endpackage

// File: rtl/al422_bam_row_reader_slot_assembler.sv
// Serial-to-parallel collector for one BAM bit plane.
// One bit arrives per capture_en cycle, in FIFO slot order. After the last
// slot of a pixel, the full word is published on pixel_word, and this word
// includes the bit captured on that same edge. pixel_complete is
// combinational and marks the edge that captures the last slot.
// Byte order follows AL422_BAM_BGR_EN (see al422_bam_pkg).
module al422_bam_slot_assembler
  import al422_bam_pkg::*;
#(
  parameter int SLOTS = 6
) (
  input  logic             in_clk,
  input  logic             in_nrst,
  input  logic             clear,
  input  logic             capture_en,
  input  logic             bit_in,
  output logic [SLOTS-1:0] pixel_word,
  output logic             pixel_complete
);

  localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] lane_base;
  logic [1:0]        color_idx;
  logic [SLOTS-1:0]  bits_q;
  logic [SLOTS-1:0]  bits_next;
  logic [SLOT_W-1:0] bit_pos;
  logic              last_slot;

  // Place the incoming bit at its colour position within the partial word.
  always_comb begin
    bit_pos            = SLOT_W'(slot_bit_pos(int'(lane_base), int'(color_idx)));
    bits_next          = bits_q;
    bits_next[bit_pos] = bit_in;
    last_slot          = (slot_cnt == SLOT_W'(SLOTS - 1));
    pixel_complete     = capture_en & last_slot;
  end

  // Slot counter walks lanes and colours, and wraps after the last slot.
  // Clearing does not touch pixel_word, so the output holds between rows.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      slot_cnt   <= '0;
      lane_base  <= '0;
      color_idx  <= '0;
      bits_q     <= '0;
      pixel_word <= '0;
    end else if (clear) begin
      slot_cnt  <= '0;
      lane_base <= '0;
      color_idx <= '0;
      bits_q    <= '0;
    end else if (capture_en) begin
      bits_q <= bits_next;
      if (last_slot) begin
        slot_cnt   <= '0;
        lane_base  <= '0;
        color_idx  <= '0;
        pixel_word <= bits_next;
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
        if (color_idx == 2'd2) begin
          color_idx <= 2'd0;
          lane_base <= lane_base + SLOT_W'(3);
        end else begin
          color_idx <= color_idx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/al422_bam_row_reader.sv
// AL422 BAM row reader: reads one row of pixel bytes from the AL422 FIFO and
// slices out one BAM bit plane. It drives CHANNELS parallel RGB lanes, with
// one led_clk strobe per pixel.
// Optional build macro: AL422_BAM_BGR_EN (B,G,R byte order per lane).
//
// Handshake: the sequencer raises start. The request is accepted on an edge
// where busy=0, and start is ignored while busy=1. busy stays high until the
// edge that captures the last slot of the last pixel. row_done then rises
// and stays high until the next accept. The final led_clk pulse follows one
// edge after busy falls.
//
// Timeline for accept edge E0: al422_re is low for TOTAL cycles, E0..E0+TOTAL.
// The FIFO drives byte i during the cycle after E(i+1). data_buf registers it
// at E(i+2), and the slot is captured at E(i+3).
module al422_bam_row_reader
  import al422_bam_pkg::*;
#(
  parameter int PIXEL_COUNT = 64,
  parameter int CHANNELS    = 2,
  parameter int COLOR_BITS  = 8,
  parameter int BITIDX_W    = $clog2(COLOR_BITS)
) (
  input  logic                  in_clk,
  input  logic                  in_nrst,
  input  logic [COLOR_BITS-1:0] in_data,
  input  logic [BITIDX_W-1:0]   bit_index,
  input  logic                  start,
  input  logic                  from_zero_address,
  output logic [3*CHANNELS-1:0] rgb_out,
  output logic                  led_clk,
  output logic                  al422_re,
  output logic                  al422_nrst,
  output logic                  busy,
  output logic                  row_done
);

  localparam int SLOTS = slots_per_pixel(CHANNELS);
  localparam int TOTAL = total_reads(PIXEL_COUNT, CHANNELS);
  localparam int REQ_W = $clog2(TOTAL + 1);
  localparam int PIX_W = $clog2(PIXEL_COUNT);

  logic [COLOR_BITS-1:0] data_buf;
  logic [COLOR_BITS-1:0] data_shifted;
  logic [BITIDX_W-1:0]   bit_index_l;
  logic [REQ_W-1:0]      req_cnt;
  logic [PIX_W-1:0]      pix_cnt;
  logic                  rd_d1;
  logic                  rd_d2;
  logic                  led_pend;
  logic                  accept;
  logic                  capture_en;
  logic                  capture_bit;
  logic                  last_pixel;
  logic [SLOTS-1:0]      pixel_word;
  logic                  pixel_complete;

  // Accept decode and bit-plane select. An index past the byte shifts the
  // byte out completely, so the extracted bit is 0.
  always_comb begin
    accept       = start & ~busy;
    capture_en   = rd_d2 & busy;
    data_shifted = data_buf >> bit_index_l;
    capture_bit  = data_shifted[0];
    last_pixel   = (pix_cnt == PIX_W'(PIXEL_COUNT - 1));
  end

  // Register the FIFO data bus every cycle.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) data_buf <= '0;
    else          data_buf <= in_data;
  end

  // Row control: accept, AL422 read enable and rewind, request counting,
  // and end of row.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      busy        <= 1'b0;
      row_done    <= 1'b0;
      al422_re    <= 1'b1;
      al422_nrst  <= 1'b1;
      bit_index_l <= '0;
      req_cnt     <= '0;
    end else if (accept) begin
      busy        <= 1'b1;
      row_done    <= 1'b0;
      al422_re    <= 1'b0;
      al422_nrst  <= ~from_zero_address;
      bit_index_l <= bit_index;
      req_cnt     <= '0;
    end else begin
      al422_nrst <= 1'b1;
      if (!al422_re) begin
        req_cnt <= req_cnt + REQ_W'(1);
        if (req_cnt == REQ_W'(TOTAL - 1)) al422_re <= 1'b1;
      end
      if (pixel_complete && last_pixel) begin
        busy     <= 1'b0;
        row_done <= 1'b1;
      end
    end
  end

  // Delay the read window by two cycles (FIFO latency + data_buf) to form the capture window.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      rd_d1 <= 1'b0;
      rd_d2 <= 1'b0;
    end else begin
      rd_d1 <= ~al422_re;
      rd_d2 <= rd_d1;
    end
  end

  // Pixel counter: advances on each completed pixel and wraps after the last.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      pix_cnt <= '0;
    end else if (accept) begin
      pix_cnt <= '0;
    end else if (pixel_complete) begin
      pix_cnt <= last_pixel ? '0 : pix_cnt + PIX_W'(1);
    end
  end

  // led_clk rises one edge after the pixel word updates and lasts one cycle.
  always_ff @(posedge in_clk or negedge in_nrst) begin
    if (!in_nrst) begin
      led_pend <= 1'b0;
      led_clk  <= 1'b0;
    end else begin
      led_pend <= pixel_complete;
      led_clk  <= led_pend;
    end
  end

  al422_bam_slot_assembler #(
    .SLOTS(SLOTS)
  ) u_slot_assembler (
    .in_clk        (in_clk),
    .in_nrst       (in_nrst),
    .clear         (accept),
    .capture_en    (capture_en),
    .bit_in        (capture_bit),
    .pixel_word    (pixel_word),
    .pixel_complete(pixel_complete)
  );

  assign rgb_out = pixel_word;

endmodule

// File: tb/tb_al422_bam_row_reader.sv
// Bench for al422_bam_row_reader with PIXEL_COUNT=4, CHANNELS=2.
// A negedge-driven AL422 model serves bytes from mem[] and logs every byte it
// delivers. Expected pixels are rebuilt from that log using the slot/colour
// rules. Event timing is checked against the row timeline relative to E0.
module tb_al422_bam_row_reader;

  localparam int PIXEL_COUNT = 4;
  localparam int CHANNELS    = 2;
  localparam int SLOTS       = 6;
  localparam int TOTAL       = 24;

  logic       in_clk = 1'b0;
  logic       in_nrst;
  logic [7:0] in_data;
  logic [2:0] bit_index;
  logic       start;
  logic       from_zero_address;
  logic [5:0] rgb_out;
  logic       led_clk;
  logic       al422_re;
  logic       al422_nrst;
  logic       busy;
  logic       row_done;

  al422_bam_row_reader #(
    .PIXEL_COUNT(PIXEL_COUNT),
    .CHANNELS   (CHANNELS),
    .COLOR_BITS (8)
  ) dut (
    .in_clk           (in_clk),
    .in_nrst          (in_nrst),
    .in_data          (in_data),
    .bit_index        (bit_index),
    .start            (start),
    .from_zero_address(from_zero_address),
    .rgb_out          (rgb_out),
    .led_clk          (led_clk),
    .al422_re         (al422_re),
    .al422_nrst       (al422_nrst),
    .busy             (busy),
    .row_done         (row_done)
  );

  // Clock and cycle index (cyc = number of rising edges so far).
  always #5 in_clk = ~in_clk;
  int cyc = 0;
  always @(posedge in_clk) cyc++;

  int vectors    = 0;
  int miscompares = 0;

  // AL422 model: a read enabled during one cycle delivers the next byte half a cycle after the following edge.
  logic [7:0] mem [64];
  logic [7:0] rd_log [$];
  int         rd_ptr  = 0;
  logic       re_prev = 1'b1;
  always @(negedge in_clk) begin
    if (re_prev == 1'b0) begin
      in_data = mem[rd_ptr % 64];
      rd_log.push_back(in_data);
      rd_ptr++;
    end else begin
      in_data = 8'($urandom);
    end
    if (al422_nrst == 1'b0) rd_ptr = 0;
    re_prev = al422_re;
  end

  // Monitor: log strobes and level statistics each cycle.
  logic [5:0] led_rgb_q [$];
  int         led_cyc_q [$];
  int         re_low_cnt    = 0;
  int         nrst_low_cnt  = 0;
  int         nrst_low_cyc  = -1;
  int         busy_fall_cyc = -1;
  int         done_rise_cyc = -1;
  logic       busy_prev = 1'b0;
  logic       done_prev = 1'b0;
  always @(negedge in_clk) begin
    if (led_clk === 1'b1) begin
      led_rgb_q.push_back(rgb_out);
      led_cyc_q.push_back(cyc);
    end
    if (al422_re === 1'b0) re_low_cnt++;
    if (al422_nrst === 1'b0) begin
      nrst_low_cnt++;
      nrst_low_cyc = cyc;
    end
    if (busy_prev === 1'b1 && busy === 1'b0) busy_fall_cyc = cyc;
    if (done_prev === 1'b0 && row_done === 1'b1) done_rise_cyc = cyc;
    busy_prev = busy;
    done_prev = row_done;
  end

  task automatic tick();
    @(negedge in_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference pixel: lane c's bytes are slots 3c..3c+2 of the pixel.
  function automatic logic [5:0] exp_pixel(input int base, input int p, input logic [2:0] bidx);
    logic [5:0] w;
    logic [7:0] b;
    int         pos;
    w = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int k = 0; k < 3; k++) begin
        b = rd_log[base + p * SLOTS + 3 * c + k];
`ifdef AL422_BAM_BGR_EN
        pos = 3 * c + (2 - k);
`else
        pos = 3 * c + k;
`endif
        w[pos] = b[bidx];
      end
    end
    return w;
  endfunction

  task automatic chk_reset_values(input string tag);
    chk({tag, "_rgb"},  32'(rgb_out),    32'h0);
    chk({tag, "_led"},  32'(led_clk),    32'h0);
    chk({tag, "_re"},   32'(al422_re),   32'h1);
    chk({tag, "_nrst"}, 32'(al422_nrst), 32'h1);
    chk({tag, "_busy"}, 32'(busy),       32'h0);
    chk({tag, "_done"}, 32'(row_done),   32'h0);
  endtask

  // One row. mode bit0: change bit_index mid-row; bit1: start pulse while
  // busy; bit2: start exactly on the final slot edge.
  task automatic do_row(input logic [2:0] bidx, input logic fza, input int mode, input string name);
    int pbase, rbase, nbase, lbase, e0, rel, npulse;
    pbase = led_cyc_q.size();
    rbase = re_low_cnt;
    nbase = nrst_low_cnt;
    lbase = rd_log.size();
    bit_index = bidx;
    from_zero_address = fza;
    start = 1'b1;
    tick();
    start = 1'b0;
    e0 = cyc;
    chk({name, "_acc_busy"}, 32'(busy),       32'h1);
    chk({name, "_acc_done"}, 32'(row_done),   32'h0);
    chk({name, "_acc_re"},   32'(al422_re),   32'h0);
    chk({name, "_acc_nrst"}, 32'(al422_nrst), 32'(!fza));
    for (int i = 0; i < 60; i++) begin
      if (busy !== 1'b1) break;
      rel = cyc - e0;
      if ((mode & 1) != 0 && rel == 5)  bit_index = 3'd0;
      if ((mode & 2) != 0 && rel == 10) start = 1'b1;
      if ((mode & 2) != 0 && rel == 12) start = 1'b0;
      if ((mode & 4) != 0 && rel == 25) start = 1'b1;
      tick();
    end
    start = 1'b0;
    chk({name, "_busy_timeout"}, 32'(busy), 32'h0);
    chk({name, "_busy_fall"}, 32'(busy_fall_cyc - e0), 32'(TOTAL + 2));
    chk({name, "_done_rise"}, 32'(done_rise_cyc - e0), 32'(TOTAL + 2));
    tick();
    tick();
    npulse = led_cyc_q.size() - pbase;
    chk({name, "_pulses"}, 32'(npulse), 32'(PIXEL_COUNT));
    chk({name, "_reads"}, 32'(rd_log.size() - lbase), 32'(TOTAL));
    chk({name, "_re_low"}, 32'(re_low_cnt - rbase), 32'(TOTAL));
    chk({name, "_nrst_low"}, 32'(nrst_low_cnt - nbase), 32'(fza ? 1 : 0));
    if (fza) chk({name, "_nrst_cyc"}, 32'(nrst_low_cyc - e0), 32'h0);
    if (rd_log.size() - lbase >= TOTAL) begin
      for (int p = 0; p < PIXEL_COUNT && p < npulse; p++) begin
        chk($sformatf("%s_led_cyc%0d", name, p), 32'(led_cyc_q[pbase + p] - e0), 32'(9 + SLOTS * p));
        chk($sformatf("%s_rgb%0d", name, p), 32'(led_rgb_q[pbase + p]), 32'(exp_pixel(lbase, p, bidx)));
      end
    end
    chk({name, "_end_busy"}, 32'(busy),     32'h0);
    chk({name, "_end_done"}, 32'(row_done), 32'h1);
  endtask

  initial begin
    int pbase;
    in_nrst = 1'b0;
    start = 1'b0;
    bit_index = 3'd0;
    from_zero_address = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    // Reset with the clock running.
    repeat (3) tick();
    chk_reset_values("reset");
    in_nrst = 1'b1;
    tick();

    // Bytes 01,00 repeating, plane 0.
    for (int i = 0; i < 64; i++) mem[i] = (i % 2 == 0) ? 8'h01 : 8'h00;
    do_row(3'd0, 1'b1, 0, "pat01");
    chk("pat01_rgb_const", 32'(rgb_out), 32'h15);

    // No rewind: al422_nrst must stay high.
    do_row(3'd0, 1'b0, 0, "no_rewind");

    // Plane 7 on 0x80 bytes, with bit_index changed mid-row.
    for (int i = 0; i < 64; i++) mem[i] = 8'h80;
    do_row(3'd7, 1'b1, 1, "bit7_latch");
    chk("bit7_rgb_const", 32'(rgb_out), 32'h3f);

    // Start while busy and on the final slot edge: both are ignored.
    do_row(3'd7, 1'b1, 6, "start_busy");
    // Accepted again from row_done=1.
    do_row(3'd7, 1'b1, 0, "second_row");

    // Random bytes, planes and rewind choices.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
      do_row(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, $sformatf("rand%0d", r));
    end

    // Asynchronous reset while the second led_clk pulse is high.
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    pbase = led_cyc_q.size();
    bit_index = 3'($urandom_range(0, 7));
    from_zero_address = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (led_cyc_q.size() - pbase >= 2) break;
      tick();
    end
    chk("midrst_pulse2", 32'(led_cyc_q.size() - pbase), 32'h2);
    #2;
    in_nrst = 1'b0;
    #1;
    chk_reset_values("midrst");
    tick();
    tick();
    in_nrst = 1'b1;
    tick();
    chk("midrst_idle_busy", 32'(busy), 32'h0);
    chk("midrst_idle_led_cnt", 32'(led_cyc_q.size() - pbase), 32'h2);

    // A fresh row after the reset.
    for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
    do_row(3'($urandom_range(0, 7)), 1'b1, 0, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/al422_bam_row_reader.md
Name: al422_bam_row_reader

Overview:
Parametrised successor to the single-channel BAM first stage. Reads one row of pixel bytes from the AL422 FIFO and slices out one BAM bit plane. Drives CHANNELS parallel RGB lanes (e.g. upper/lower panel halves) with an led_clk strobe per pixel. Sits between the AL422 read port and the panel latch/OE sequencer, which issues start and consumes row_done.

Parameters:
PIXEL_COUNT, 64, pixels shifted per row per channel (≥2)
CHANNELS, 2, parallel RGB lanes; bytes per pixel SLOTS = 3*CHANNELS
COLOR_BITS, 8, width of one colour byte / AL422 data bus
BITIDX_W, $clog2(COLOR_BITS), width of bit_index

Ports:
in_clk  input  1  clock
in_nrst  input  1  reset, asynchronous, active-low
in_data  input  COLOR_BITS  AL422 data out
bit_index  input  BITIDX_W  BAM bit plane to extract; latched at start
start  input  1  row request; accepted only when busy=0
from_zero_address  input  1  at accept: pulse al422_nrst to rewind the FIFO read pointer
rgb_out  output  3*CHANNELS  lane c occupies bits [3c+2:3c], order {B,G,R}
led_clk  output  1  one-cycle shift strobe per pixel
al422_re  output  1  AL422 read enable, active-low
al422_nrst  output  1  AL422 read-pointer reset, active-low
busy  output  1  row in progress
row_done  output  1  sticky: last row complete; cleared by next accept

Behaviour:
- Reset values: rgb_out=0, led_clk=0, al422_re=1, al422_nrst=1, busy=0, row_done=0. All internal counters are 0.
- Accept at edge E0 when start=1 & busy=0. At E0:
  - busy←1, row_done←0, al422_re←0.
  - al422_nrst←!from_zero_address.
  - bit_index latched; slot, pixel and request counters cleared.
- At E1: al422_nrst←1. It is therefore low for exactly one cycle, and only when requested.
- start while busy=1 is ignored. start with row_done=1 and busy=0 is accepted normally.
- in_data is registered every cycle into data_buf.
- Request counter counts cycles with al422_re=0. al422_re←1 at edge E0+TOTAL, where TOTAL = SLOTS*PIXEL_COUNT, so al422_re is low for exactly TOTAL cycles.
- Slot capture:
  - Starts at E3 with one slot per edge: slot s ← data_buf[bit_index_l].
  - Slot order per pixel: lane0 R,G,B, then lane1 R,G,B, and so on.
  - Slot counter wraps SLOTS-1 → 0.
- At the edge capturing slot SLOTS-1:
  - rgb_out ← assembled bits, including the bit captured at this edge.
  - pixel counter increments.
  - led_clk ←1 at the next edge and 0 the edge after (one-cycle pulse). rgb_out is therefore stable ≥1 cycle before the led_clk rise.
- Last pixel (pixel counter = PIXEL_COUNT-1) at slot SLOTS-1, i.e. edge E0+TOTAL+2:
  - busy←0, row_done←1, pixel counter wraps to 0.
  - The final led_clk pulse occurs at E0+TOTAL+3, after busy falls.
- rgb_out holds its last value between rows.
- Exactly PIXEL_COUNT led_clk pulses per row.
- bit_index ≥ COLOR_BITS (non-power-of-two widths): the extracted bit is 0.
- Asynchronous reset mid-row: immediately returns to reset values. An in-flight led_clk pulse is dropped. The next start behaves as from cold.
- A new start coinciding with the final slot edge is ignored, because busy is still 1 at that edge.

Optional Feature:
AL422_BAM_BGR_EN.
- Defined: per-lane byte order in the FIFO is B,G,R. Slot 3c captures B, slot 3c+2 captures R. rgb_out bit mapping is unchanged ({B,G,R}).
- Undefined: the order is R,G,B as above.

Decomposition:
- Package al422_bam_pkg holds:
  - localparams RGB_R=0, RGB_G=1, RGB_B=2.
  - function slots_per_pixel(channels) = 3*channels.
  - function total_reads(pixels, channels).
- Sub-module al422_bam_slot_assembler: the slot counter plus serial-to-parallel bit collector. It has inputs capture_en, bit_in and clear, and outputs the pixel word and pixel_complete.
- The top module keeps the accept logic, request counter, pixel counter and AL422 controls.

Test Plan:
All scenarios use PIXEL_COUNT=4, CHANNELS=2 (SLOTS=6, TOTAL=24).
- Reset asserted with clock running → rgb_out=0, led_clk=0, al422_re=1, al422_nrst=1, busy=0, row_done=0.
- Start, bit_index=0, FIFO bytes repeating 01,00,01,00,01,00 → rgb_out=6'b010101 for every pixel. Expect 4 led_clk pulses, al422_re low exactly 24 cycles, busy low and row_done high at E0+26, last led_clk at E0+27.
- Start with from_zero_address=1 → al422_nrst low for exactly cycle E0..E1. With from_zero_address=0 → al422_nrst never low.
- bit_index=7, all bytes 0x80; bit_index changed to 0 mid-row → rgb_out=6'b111111 for all 4 pixels (latched index used).
- start pulsed while busy → no effect on counters or al422_re. start after row_done=1 → row_done clears at accept and a second identical row follows.
- in_nrst asserted at pixel 2 → immediate reset values. A fresh start produces a full 4-pixel row with correct data.
